mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one `mux_8x1` datapath between eight single-bit requesters. It picks one requester at a time and drives the mux select. It then streams that requester's data bit over a valid/ready output for a bounded burst before rotating priority. It sits in front of the 8:1 multiplexer tree and instantiates `mux_8x1` internally as its datapath.

---
 rtl/mux8_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter -- round-robin arbiter in front of an 8:1 single-bit mux.
//
// The arbiter picks one of eight requesters and drives the mux select.
// It then streams the winner's data bit over a valid/ready port for up to
// BURST_LEN accepted beats. After that it returns to IDLE for one cycle and
// rotates priority to the channel after the one just served.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   req[7:0]   in   per-channel request lines
//   data_in    in   per-channel data bits (bit i -> mux input i, A..H)
//   out_ready  in   downstream accepts a beat this cycle
//   grant      out  registered one-hot (or zero) grant
//   sel        out  registered mux select
//   out_data   out  data_in[sel], combinational through mux_8x1
//   out_valid  out  (state==GRANT) & req[sel], combinational
//   burst_done out  one-cycle registered pulse when a grant ends

// Plain 8:1 single-bit multiplexer: this is the shared datapath.
module mux_8x1 (
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic       H,
  input  logic [2:0] S,
  output logic       Y
);
  always_comb begin
    Y = A;
    unique case (S)
      3'd0: Y = A;
      3'd1: Y = B;
      3'd2: Y = C;
      3'd3: Y = D;
      3'd4: Y = E;
      3'd5: Y = F;
      3'd6: Y = G;
      3'd7: Y = H;
      default: Y = A;
    endcase
  end
endmodule

module mux8_rr_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  input  logic       out_ready,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       out_data,
  output logic       out_valid,
  output logic       burst_done
);

  localparam int NUM_CH = 8;
  localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [7:0]  grant_q, grant_d;
  logic [2:0]  sel_q,   sel_d;
  logic [2:0]  ptr_q,   ptr_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic        done_q,  done_d;

  // Request vector rotated so that bit k is channel (ptr+k) mod 8. The
  // first set bit of rot_req is then the round-robin winner's offset from ptr.
  logic [NUM_CH-1:0] rot_req;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_rot
    assign rot_req[k] = req[ptr_q + 3'(k)];
  end

  logic [2:0] win_ofs;
  logic [2:0] win;
  always_comb begin
    win_ofs = 3'd0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot_req[k]) win_ofs = 3'(k);
    end
  end
  assign win = ptr_q + win_ofs;

  // Datapath: the mux is driven only by the registered select.
  mux_8x1 u_mux (
    .A (data_in[0]),
    .B (data_in[1]),
    .C (data_in[2]),
    .D (data_in[3]),
    .E (data_in[4]),
    .F (data_in[5]),
    .G (data_in[6]),
    .H (data_in[7]),
    .S (sel_q),
    .Y (out_data)
  );

  // out_valid deliberately ignores out_ready so downstream may close a
  // combinational loop through out_ready without creating one here.
  logic xfer;
  assign out_valid = (state_q == GRANT) & req[sel_q];
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Arbitration uses req as seen in this IDLE cycle only.
        if (req != 8'h00) begin
          state_d = GRANT;
          grant_d = 8'h01 << win;
          sel_d   = win;
          cnt_d   = 5'd0;
        end
      end
      GRANT: begin
        // Withdrawal and last accepted beat both end the grant; a withdrawn
        // requester has out_valid low, so no beat is lost in that case.
        if (!req[sel_q] || (xfer && cnt_q == LAST_BEAT)) begin
          state_d = IDLE;
          grant_d = 8'h00;
          ptr_d   = sel_q + 3'd1;
          done_d  = 1'b1;
        end else if (xfer) begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign grant      = grant_q;
  assign sel        = sel_q;
  assign burst_done = done_q;

  // Structural invariants of the grant/count state.
  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_q));
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= LAST_BEAT);
  a_grant_state : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == GRANT) == (grant_q != 8'h00));

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter (BURST_LEN=4). Inputs change 1 time
// unit after a rising edge; outputs are sampled at that point as well.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data_in;
  logic       out_ready;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       out_data;
  logic       out_valid;
  logic       burst_done;

  int total = 0;
  int bad   = 0;

  mux8_rr_arbiter #(.BURST_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data_in    (data_in),
    .out_ready  (out_ready),
    .grant      (grant),
    .sel        (sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .burst_done (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after a grant edge: expects four granted
  // cycles with continuous transfers, then the end-of-burst pulse.
  task automatic burst_chk(input string tag, input int ch);
    logic [7:0] oh;
    logic [7:0] d;
    oh = 8'h01 << ch;
    d  = data_in;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".grant"}, 32'(grant), 32'(oh));
      chk({tag, ".sel"},   32'(sel),   32'(ch));
      chk({tag, ".vld"},   32'(out_valid), 32'd1);
      chk({tag, ".data"},  32'(out_data),  32'(d[ch]));
      chk({tag, ".done0"}, 32'(burst_done), 32'd0);
      tick();
    end
    chk({tag, ".done1"},  32'(burst_done), 32'd1);
    chk({tag, ".gnt0"},   32'(grant), 32'd0);
    chk({tag, ".vldidl"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 8'h00;
    data_in   = 8'h00;
    out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.sel",   32'(sel),   32'd0);
    chk("rst.vld",   32'(out_valid), 32'd0);
    chk("rst.done",  32'(burst_done), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single requester ch3, full burst, then re-grant after one IDLE cycle
    req = 8'h08; data_in = 8'h08;
    tick();
    burst_chk("single", 3);
    tick();
    chk("regrant.grant", 32'(grant), 32'h08);
    chk("regrant.sel",   32'(sel),   32'd3);
    chk("regrant.done",  32'(burst_done), 32'd0);
    req = 8'h00;
    #1;
    chk("wd3.vld", 32'(out_valid), 32'd0);
    tick();
    chk("wd3.done", 32'(burst_done), 32'd1);
    tick();
    chk("idle.done",  32'(burst_done), 32'd0);
    chk("idle.grant", 32'(grant), 32'd0);
    chk("idle.sel",   32'(sel),   32'd3);

    // Reset mid-grant: ptr is 4 here, so req=FF grants ch4 first
    req = 8'hFF;
    tick();
    chk("pre.grant", 32'(grant), 32'h10);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.grant", 32'(grant), 32'd0);
    chk("arst.sel",   32'(sel),   32'd0);
    chk("arst.vld",   32'(out_valid), 32'd0);
    chk("arst.done",  32'(burst_done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post.grant", 32'(grant), 32'h01);
    chk("post.sel",   32'(sel),   32'd0);

    // Rotation between ch0 and ch7
    req = 8'h81; data_in = 8'h80;
    burst_chk("rr0a", 0);
    tick();
    burst_chk("rr7a", 7);
    tick();
    burst_chk("rr0b", 0);
    tick();
    burst_chk("rr7b", 7);

    // Wrap-around: ptr back at 0, next is ch1 then ch6
    req = 8'h42; data_in = 8'h02;
    tick();
    burst_chk("wrap1", 1);
    tick();
    burst_chk("wrap6", 6);

    // Backpressure on ch2: transfers on cycles 1,4,5,7
    req = 8'h04; data_in = 8'h04;
    tick();
    chk("bp.grant", 32'(grant), 32'h04);
    for (int k = 0; k < 7; k++) begin
      logic [6:0] pat;
      pat = 7'b1011001;   // bit k = out_ready for cycle k+1
      out_ready = pat[k];
      chk("bp.vld",   32'(out_valid), 32'd1);
      chk("bp.data",  32'(out_data),  32'd1);
      tick();
      chk("bp.done",  32'(burst_done), (k == 6) ? 32'd1 : 32'd0);
      chk("bp.gnt",   32'(grant),      (k == 6) ? 32'd0 : 32'h04);
    end
    out_ready = 1'b1;

    // Early withdrawal of ch5 after two transfers; ptr must become 6
    req = 8'h20;
    tick();
    chk("wd.grant", 32'(grant), 32'h20);
    tick();
    tick();
    chk("wd.still", 32'(grant), 32'h20);
    req = 8'h00;
    #1;
    chk("wd.vld", 32'(out_valid), 32'd0);
    tick();
    chk("wd.done",  32'(burst_done), 32'd1);
    chk("wd.gnt0",  32'(grant), 32'd0);
    chk("wd.sel",   32'(sel),   32'd5);
    req = 8'h60;
    tick();
    chk("wd.next",  32'(grant), 32'h40);
    chk("wd.nsel",  32'(sel),   32'd6);
    chk("wd.ndone", 32'(burst_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
